// File: rtl/guess_sweep_ctrl_if.sv
// guess_sweep_ctrl_if
// Handshake between the sweep controller and send_guess.
//   begin_transaction : controller -> send_guess, request one guess transaction
//   guess_byte        : controller -> send_guess, candidate driven into the guess word
//   waiting_for_reply : send_guess -> controller, high while the MCU reply is outstanding
interface guess_sweep_ctrl_if;
  logic       begin_transaction;
  logic [7:0] guess_byte;
  logic       waiting_for_reply;

  modport master (
    output begin_transaction,
    output guess_byte,
    input  waiting_for_reply
  );

  modport slave (
    input  begin_transaction,
    input  guess_byte,
    output waiting_for_reply
  );
endinterface

// File: rtl/guess_sweep_ctrl.sv
// guess_sweep_ctrl
// Sequences one byte-position sweep of the timing attack: walks guess_byte from
// RANGE_LO to RANGE_HI, fires REPEATS send_guess transactions per candidate,
// accumulates the measured reply delays and reports the candidate with the
// largest total.
// Ports:
//   CLK_50      : system clock
//   SW          : asynchronous active-high reset
//   start       : one-cycle pulse, begin a sweep (ignored while busy)
//   abort       : level, cancel the sweep in progress
//   bus         : send_guess handshake (begin_transaction, guess_byte, waiting_for_reply)
//   busy        : high in any state except IDLE
//   done        : one-cycle pulse, sweep completed normally
//   best_byte   : candidate with the largest accumulated delay
//   best_acc    : accumulated delay of best_byte
//   timeout_err : sticky, cleared by reset or an accepted start
module guess_sweep_ctrl #(
  parameter int unsigned          REPEATS  = 4,
  parameter int unsigned          DELAY_W  = 24,
  parameter logic [7:0]           RANGE_LO = 8'h06,
  parameter logic [7:0]           RANGE_HI = 8'hFF,
  parameter logic [DELAY_W-1:0]   TIMEOUT  = 24'hFFFFFF,
  localparam int unsigned         ACC_W    = DELAY_W + $clog2(REPEATS) + 1
) (
  input  logic                     CLK_50,
  input  logic                     SW,
  input  logic                     start,
  input  logic                     abort,
  guess_sweep_ctrl_if.master       bus,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               best_byte,
  output logic [ACC_W-1:0]         best_acc,
  output logic                     timeout_err
);

  localparam int unsigned REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, MEASURE, ACCUM, NEXT, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         guess_q, guess_d;
  logic [7:0]         best_byte_q, best_byte_d;
  logic [ACC_W-1:0]   best_acc_q, best_acc_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [DELAY_W-1:0] wait_q, wait_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               terr_q, terr_d;

  // State and datapath registers
  always_ff @(posedge CLK_50 or posedge SW) begin
    if (SW) begin
      state_q     <= IDLE;
      guess_q     <= RANGE_LO;
      best_byte_q <= RANGE_LO;
      best_acc_q  <= '0;
      acc_q       <= '0;
      rep_q       <= '0;
      wait_q      <= '0;
      delay_q     <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      guess_q     <= guess_d;
      best_byte_q <= best_byte_d;
      best_acc_q  <= best_acc_d;
      acc_q       <= acc_d;
      rep_q       <= rep_d;
      wait_q      <= wait_d;
      delay_q     <= delay_d;
      terr_q      <= terr_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    guess_d     = guess_q;
    best_byte_d = best_byte_q;
    best_acc_d  = best_acc_q;
    acc_d       = acc_q;
    rep_d       = rep_q;
    wait_d      = wait_q;
    delay_d     = delay_q;
    terr_d      = terr_q;

    if (abort) begin
      // Abort freezes every register (partial best_* survive) and only
      // returns the FSM to IDLE; in IDLE it also suppresses start.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d       = '0;
            rep_d       = '0;
            best_acc_d  = '0;
            terr_d      = 1'b0;
            wait_d      = '0;
            guess_d     = RANGE_LO;
            best_byte_d = RANGE_LO;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (bus.waiting_for_reply) begin
            delay_d = DELAY_W'(1);
            state_d = MEASURE;
          end else if (wait_q == TIMEOUT - DELAY_W'(1)) begin
            // This cycle is the TIMEOUT-th one spent waiting for the ack
            terr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + DELAY_W'(1);
          end
        end
        MEASURE: begin
          if (bus.waiting_for_reply) begin
            if (delay_q == TIMEOUT) begin
              terr_d = 1'b1;
            end else begin
              delay_d = delay_q + DELAY_W'(1);
            end
          end else begin
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          acc_d = acc_q + ACC_W'(delay_q);
          if (rep_q == REP_W'(REPEATS - 1)) begin
            state_d = NEXT;
          end else begin
            rep_d   = rep_q + REP_W'(1);
            wait_d  = '0;
            state_d = ISSUE;
          end
        end
        NEXT: begin
          if (acc_q > best_acc_q) begin
            best_acc_d  = acc_q;
            best_byte_d = guess_q;
          end
          if (guess_q == RANGE_HI) begin
            state_d = FINISH;
          end else begin
            guess_d = guess_q + 8'd1;
            acc_d   = '0;
            rep_d   = '0;
            wait_d  = '0;
            state_d = ISSUE;
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    bus.begin_transaction = (state_q == ISSUE);
    busy                  = (state_q != IDLE);
    done                  = (state_q == FINISH);
  end

  assign bus.guess_byte = guess_q;
  assign best_byte      = best_byte_q;
  assign best_acc       = best_acc_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_guess_sweep_ctrl.sv
module tb_guess_sweep_ctrl;
  localparam int ACC_W = 26;  // 24 + $clog2(2) + 1

  logic             CLK_50 = 1'b0;
  logic             SW     = 1'b1;
  logic             start  = 1'b0;
  logic             abort  = 1'b0;
  logic             busy, done, timeout_err;
  logic [7:0]       best_byte;
  logic [ACC_W-1:0] best_acc;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  guess_sweep_ctrl_if bus();

  guess_sweep_ctrl #(
    .REPEATS (2),
    .DELAY_W (24),
    .RANGE_LO(8'h06),
    .RANGE_HI(8'h08),
    .TIMEOUT (24'd100)
  ) dut (
    .CLK_50     (CLK_50),
    .SW         (SW),
    .start      (start),
    .abort      (abort),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .best_byte  (best_byte),
    .best_acc   (best_acc),
    .timeout_err(timeout_err)
  );

  always #10 CLK_50 = ~CLK_50;

  always @(negedge CLK_50) if (done === 1'b1) done_cnt++;

  task automatic pulse_start();
    @(negedge CLK_50) start = 1'b1;
    @(negedge CLK_50) start = 1'b0;
  endtask

  // send_guess stand-in: waits for a request, then holds waiting high n cycles
  task automatic run_txn(input int n);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK_50);
      if (bus.begin_transaction === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL txn_request: begin_transaction never rose, need 1");
    end
    bus.waiting_for_reply = 1'b1;
    repeat (n) @(negedge CLK_50);
    bus.waiting_for_reply = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge CLK_50);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_idle: busy stuck at %b, need 0", busy);
    end
  endtask

  task automatic test_reset();
    SW = 1'b1;
    repeat (2) @(negedge CLK_50);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b need 0", done); end
    n_cmp++; if (bus.begin_transaction !== 1'b0) begin n_bad++; $display("FAIL rst_begin: got %b need 0", bus.begin_transaction); end
    n_cmp++; if (bus.guess_byte !== 8'h06) begin n_bad++; $display("FAIL rst_guess: got %h need 06", bus.guess_byte); end
    n_cmp++; if (best_byte !== 8'h06) begin n_bad++; $display("FAIL rst_best_byte: got %h need 06", best_byte); end
    n_cmp++; if (best_acc !== '0) begin n_bad++; $display("FAIL rst_best_acc: got %0d need 0", best_acc); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr: got %b need 0", timeout_err); end
    SW = 1'b0;
    @(negedge CLK_50);
  endtask

  task automatic test_sweep();
    done_cnt = 0;
    pulse_start();
    run_txn(10); run_txn(10);
    run_txn(30); run_txn(30);
    run_txn(20); run_txn(20);
    wait_idle();
    n_cmp++; if (best_byte !== 8'h07) begin n_bad++; $display("FAIL sweep_best_byte: got %h need 07", best_byte); end
    n_cmp++; if (best_acc !== 26'd60) begin n_bad++; $display("FAIL sweep_best_acc: got %0d need 60", best_acc); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL sweep_done_cnt: got %0d need 1", done_cnt); end
    n_cmp++; if (bus.guess_byte !== 8'h08) begin n_bad++; $display("FAIL sweep_guess_hold: got %h need 08", bus.guess_byte); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL sweep_terr: got %b need 0", timeout_err); end
  endtask

  task automatic test_tie();
    done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) run_txn(5);
    wait_idle();
    n_cmp++; if (best_byte !== 8'h06) begin n_bad++; $display("FAIL tie_best_byte: got %h need 06", best_byte); end
    n_cmp++; if (best_acc !== 26'd10) begin n_bad++; $display("FAIL tie_best_acc: got %0d need 10", best_acc); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL tie_done_cnt: got %0d need 1", done_cnt); end
  endtask

  task automatic test_ack_timeout();
    int cnt = 0;
    done_cnt = 0;
    @(negedge CLK_50) start = 1'b1;
    @(posedge CLK_50) #1 start = 1'b0;
    while (cnt < 300) begin
      @(posedge CLK_50) #1 cnt++;
      if (busy === 1'b0) break;
    end
    n_cmp++; if (cnt !== 100) begin n_bad++; $display("FAIL ack_timeout_cycles: got %0d need 100", cnt); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL ack_timeout_terr: got %b need 1", timeout_err); end
    n_cmp++; if (bus.begin_transaction !== 1'b0) begin n_bad++; $display("FAIL ack_timeout_begin: got %b need 0", bus.begin_transaction); end
    @(negedge CLK_50);
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL ack_timeout_done: got %0d need 0", done_cnt); end
  endtask

  task automatic test_sample_clamp();
    done_cnt = 0;
    pulse_start();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL clamp_start_clears_terr: got %b need 0", timeout_err); end
    run_txn(150); run_txn(10);
    run_txn(10);  run_txn(10);
    run_txn(10);  run_txn(10);
    wait_idle();
    n_cmp++; if (best_byte !== 8'h06) begin n_bad++; $display("FAIL clamp_best_byte: got %h need 06", best_byte); end
    n_cmp++; if (best_acc !== 26'd110) begin n_bad++; $display("FAIL clamp_best_acc: got %0d need 110", best_acc); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL clamp_terr: got %b need 1", timeout_err); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL clamp_done_cnt: got %0d need 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit ok = 0;
    done_cnt = 0;
    pulse_start();
    run_txn(150); run_txn(10);
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK_50);
      if (bus.begin_transaction === 1'b1) begin ok = 1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_request: begin_transaction never rose, need 1"); end
    n_cmp++; if (bus.guess_byte !== 8'h07) begin n_bad++; $display("FAIL abort_guess: got %h need 07", bus.guess_byte); end
    bus.waiting_for_reply = 1'b1;
    repeat (3) @(negedge CLK_50);
    abort = 1'b1;
    @(negedge CLK_50) abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b need 0", busy); end
    n_cmp++; if (bus.begin_transaction !== 1'b0) begin n_bad++; $display("FAIL abort_begin: got %b need 0", bus.begin_transaction); end
    bus.waiting_for_reply = 1'b0;
    @(negedge CLK_50);
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done: got %0d need 0", done_cnt); end
    n_cmp++; if (best_byte !== 8'h06) begin n_bad++; $display("FAIL abort_best_byte: got %h need 06", best_byte); end
    n_cmp++; if (best_acc !== 26'd110) begin n_bad++; $display("FAIL abort_best_acc: got %0d need 110", best_acc); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL abort_terr: got %b need 1", timeout_err); end
    // start together with abort in IDLE must not launch a sweep
    @(negedge CLK_50) begin start = 1'b1; abort = 1'b1; end
    @(negedge CLK_50) begin start = 1'b0; abort = 1'b0; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy: got %b need 0", busy); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL start_abort_terr: got %b need 1", timeout_err); end
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b need 1", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL restart_terr: got %b need 0", timeout_err); end
    n_cmp++; if (best_acc !== '0) begin n_bad++; $display("FAIL restart_best_acc: got %0d need 0", best_acc); end
    n_cmp++; if (bus.guess_byte !== 8'h06) begin n_bad++; $display("FAIL restart_guess: got %h need 06", bus.guess_byte); end
    abort = 1'b1;
    @(negedge CLK_50) abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_issue_busy: got %b need 0", busy); end
  endtask

  task automatic test_reset_mid();
    done_cnt = 0;
    pulse_start();
    run_txn(10); run_txn(10);
    run_txn(10);
    // waiting dropped at this negedge; next edge moves MEASURE -> ACCUM
    @(negedge CLK_50);
    n_cmp++; if (best_acc !== 26'd20) begin n_bad++; $display("FAIL mid_pre_best_acc: got %0d need 20", best_acc); end
    SW = 1'b1;
    #1;
    n_cmp++; if (bus.guess_byte !== 8'h06) begin n_bad++; $display("FAIL mid_rst_guess: got %h need 06", bus.guess_byte); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b need 0", busy); end
    n_cmp++; if (best_acc !== '0) begin n_bad++; $display("FAIL mid_rst_best_acc: got %0d need 0", best_acc); end
    n_cmp++; if (bus.begin_transaction !== 1'b0) begin n_bad++; $display("FAIL mid_rst_begin: got %b need 0", bus.begin_transaction); end
    @(negedge CLK_50) SW = 1'b0;
    @(negedge CLK_50);
    done_cnt = 0;
    pulse_start();
    run_txn(10);
    // redundant start while busy must not disturb the sweep
    pulse_start();
    run_txn(10);
    run_txn(5); run_txn(5);
    run_txn(5); run_txn(5);
    wait_idle();
    n_cmp++; if (best_byte !== 8'h06) begin n_bad++; $display("FAIL busy_start_best_byte: got %h need 06", best_byte); end
    n_cmp++; if (best_acc !== 26'd20) begin n_bad++; $display("FAIL busy_start_best_acc: got %0d need 20", best_acc); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done_cnt: got %0d need 1", done_cnt); end
  endtask

  initial begin
    bus.waiting_for_reply = 1'b0;
    test_reset();
    test_sweep();
    test_tie();
    test_ack_timeout();
    test_sample_clamp();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
